// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] HALT_INS   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PCAddr,
    input  logic [31:0] Ins,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_Ins,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic        FetchErr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] ifid_pc_next;
    logic [31:0] ifid_ins_next;
    logic        ifid_valid_next;
    logic        fetch_err_next;
    logic        in_range;
    logic        fetch_load;
    logic        stall_tick;

    assign in_range = {2'b00, pc[31:2]} < 32'(IMEM_WORDS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a redirect always resumes fetch, an in-range EBREAK stops it
    always_comb begin
        state_next = state;
        if (Redirect) begin
            state_next = RUN;
        end else if (state == RUN && !Stall && in_range && Ins == HALT_INS) begin
            state_next = HALT;
        end
    end

    // Datapath next values; holding is the default
    always_comb begin
        pc_next         = pc;
        ifid_pc_next    = IFID_PC;
        ifid_ins_next   = IFID_Ins;
        ifid_valid_next = IFID_Valid;
        fetch_err_next  = FetchErr;
        fetch_load      = 1'b0;
        stall_tick      = 1'b0;
        if (Redirect) begin
            pc_next         = {RedirectPC[31:2], 2'b00};
            ifid_valid_next = 1'b0;
            ifid_ins_next   = NOP_INS;
            if (RedirectPC[1:0] != 2'b00) begin
                fetch_err_next = 1'b1;
            end
        end else if (state == RUN) begin
            if (Stall) begin
                stall_tick = 1'b1;
            end else begin
                ifid_pc_next    = pc;
                ifid_ins_next   = Ins;
                ifid_valid_next = in_range;
                fetch_load      = in_range;
                pc_next         = pc + 32'd4;
                if (!in_range) begin
                    fetch_err_next = 1'b1;
                end
            end
        end else if (!Stall) begin
            // HALT drains the captured EBREAK on the first unstalled edge
            ifid_valid_next = 1'b0;
            ifid_ins_next   = NOP_INS;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VEC;
            IFID_PC    <= 32'h0000_0000;
            IFID_Ins   <= NOP_INS;
            IFID_Valid <= 1'b0;
            FetchErr   <= 1'b0;
        end else begin
            pc         <= pc_next;
            IFID_PC    <= ifid_pc_next;
            IFID_Ins   <= ifid_ins_next;
            IFID_Valid <= ifid_valid_next;
            FetchErr   <= fetch_err_next;
        end
    end

    assign PCAddr = pc;
    assign Halted = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    // Free-running event counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            FetchCount <= 32'h0000_0000;
            StallCount <= 32'h0000_0000;
        end else begin
            if (fetch_load) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (stall_tick) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_load ^ stall_tick;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a reference-model scoreboard.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT_W = 32'h0010_0073;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PCAddr;
    logic [31:0] Ins;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_Ins;
    logic        IFID_Valid;
    logic        Halted;
    logic        FetchErr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ins;
        logic        valid;
        logic        halted;
        logic        err;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_ifpc, m_ins, m_fc, m_sc;
    logic        m_valid, m_halt, m_err;

    instruction_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .PCAddr    (PCAddr),
        .Ins       (Ins),
        .Stall     (Stall),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .IFID_PC   (IFID_PC),
        .IFID_Ins  (IFID_Ins),
        .IFID_Valid(IFID_Valid),
        .Halted    (Halted),
        .FetchErr  (FetchErr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount(FetchCount),
        .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word 4 holds EBREAK, all others a tagged word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'd4) return HALT_W;
        return 32'hA000_0000 | {2'b00, a[31:2]};
    endfunction

    always_comb Ins = mem_word(PCAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        logic inr;
        rst = r; Stall = s; Redirect = d; RedirectPC = t;
        if (r) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_ins = NOP_W; m_valid = 1'b0;
            m_halt = 1'b0; m_err = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
        end else if (d) begin
            m_pc = {t[31:2], 2'b00}; m_valid = 1'b0; m_ins = NOP_W; m_halt = 1'b0;
            if (t[1:0] != 2'b00) m_err = 1'b1;
        end else if (!m_halt) begin
            if (s) begin
                m_sc = m_sc + 32'd1;
            end else begin
                inr = (m_pc >> 2) < 32'd1024;
                m_ifpc = m_pc; m_ins = mem_word(m_pc); m_valid = inr;
                if (!inr) m_err = 1'b1;
                else m_fc = m_fc + 32'd1;
                if (inr && m_ins == HALT_W) m_halt = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (!s) begin
            m_valid = 1'b0; m_ins = NOP_W;
        end
        e = '{m_pc, m_ifpc, m_ins, m_valid, m_halt, m_err, m_fc, m_sc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_pcaddr", PCAddr, e.pc);
        chk("sb_ifid_pc", IFID_PC, e.ifpc);
        chk("sb_ifid_ins", IFID_Ins, e.ins);
        chk("sb_ifid_valid", 32'(IFID_Valid), 32'(e.valid));
        chk("sb_halted", 32'(Halted), 32'(e.halted));
        chk("sb_fetch_err", 32'(FetchErr), 32'(e.err));
`ifdef FETCH_PERF_CNT_EN
        chk("sb_fetch_count", FetchCount, e.fc);
        chk("sb_stall_count", StallCount, e.sc);
`endif
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;

        // Reset and straight-line fetch
        step(1, 0, 0, 32'h0);
        chk("rst_pcaddr", PCAddr, 32'h0);
        chk("rst_ifid_ins", IFID_Ins, NOP_W);
        step(0, 0, 0, 32'h0);
        chk("s1_ifid_pc0", IFID_PC, 32'h0);
        chk("s1_valid", 32'(IFID_Valid), 32'd1);
        step(0, 0, 0, 32'h0);
        chk("s1_pcaddr8", PCAddr, 32'h8);
        chk("s1_ifid_pc4", IFID_PC, 32'h4);

        // Stall for three cycles at PC=8
        repeat (3) step(0, 1, 0, 32'h0);
        chk("s2_pc_hold", PCAddr, 32'h8);
        chk("s2_ifid_hold", IFID_PC, 32'h4);
        chk("s2_ins_hold", IFID_Ins, 32'hA000_0001);
        step(0, 0, 0, 32'h0);
        chk("s2_release", IFID_PC, 32'h8);

        // Redirect wins over stall
        step(0, 1, 1, 32'h40);
        chk("s3_pcaddr", PCAddr, 32'h40);
        chk("s3_bubble", 32'(IFID_Valid), 32'd0);
        chk("s3_nop", IFID_Ins, NOP_W);
        step(0, 0, 0, 32'h0);
        chk("s3_ifid_pc", IFID_PC, 32'h40);

        // Misaligned redirect target
        step(0, 0, 1, 32'h42);
        chk("s4_pcaddr", PCAddr, 32'h40);
        chk("s4_err", 32'(FetchErr), 32'd1);
        repeat (2) step(0, 0, 0, 32'h0);
        chk("s4_err_sticky", 32'(FetchErr), 32'd1);

        // EBREAK halts fetch
        step(0, 0, 1, 32'h10);
        step(0, 0, 0, 32'h0);
        chk("s5_ebreak", IFID_Ins, HALT_W);
        chk("s5_halted", 32'(Halted), 32'd1);
        chk("s5_pc14", PCAddr, 32'h14);
        step(0, 1, 0, 32'h0);
        chk("s5_halt_stall_hold", IFID_Ins, HALT_W);
        step(0, 0, 0, 32'h0);
        chk("s5_drain", 32'(IFID_Valid), 32'd0);
        chk("s5_frozen", PCAddr, 32'h14);
        step(0, 0, 1, 32'h0);
        chk("s5_resume", 32'(Halted), 32'd0);
        step(0, 0, 0, 32'h0);
        chk("s5_fetch0", IFID_PC, 32'h0);

        // Reset while halted and stalled
        step(0, 0, 1, 32'h10);
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("s6_pc", PCAddr, 32'h0);
        chk("s6_halted", 32'(Halted), 32'd0);
        chk("s6_err", 32'(FetchErr), 32'd0);
        chk("s6_valid", 32'(IFID_Valid), 32'd0);

        // Last in-range word, then out of range
        step(0, 0, 1, 32'hFFC);
        step(0, 0, 0, 32'h0);
        chk("oor_last_valid", 32'(IFID_Valid), 32'd1);
        step(0, 0, 0, 32'h0);
        chk("oor_invalid", 32'(IFID_Valid), 32'd0);
        chk("oor_err", 32'(FetchErr), 32'd1);
        chk("oor_continue", PCAddr, 32'h1004);

        // PC wrap
        step(1, 0, 0, 32'h0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        chk("wrap_pc", PCAddr, 32'h0);
        chk("wrap_ifid_pc", IFID_PC, 32'hFFFF_FFFC);

        // Counters after four straight loads
        step(1, 0, 0, 32'h0);
        repeat (4) step(0, 0, 0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch4", FetchCount, 32'd4);
        chk("perf_stall0", StallCount, 32'd0);
`endif
        chk("perf_pc", PCAddr, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
